// File: rtl/solver_pkg.sv
// Shared definitions for the fractal solver scheduler and its arbiter.
package solver_pkg;
    localparam int          LIMB_INDEX_BITS = 6;
    localparam logic [15:0] ITER_COUNT_NONE = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2
    } sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping (N is a power of 2).
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);
    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int off = 0; off < N; off++) begin
            idx = ptr + IW'(off);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/solver_scheduler.sv
// Streams pixel jobs into free fractal solvers and returns their tagged
// iteration counts on a single round-robin arbitrated result stream.
module solver_scheduler #(
    parameter int NUM_SOLVERS     = 4,
    parameter int LIMB_INDEX_BITS = solver_pkg::LIMB_INDEX_BITS,
    parameter int LIMB_BITS       = 32,
    parameter int TAG_BITS        = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [LIMB_INDEX_BITS-1:0] cfg_num_limbs,
    input  logic [15:0]                cfg_iter_lim,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [TAG_BITS-1:0]        job_tag,
    input  logic [LIMB_BITS-1:0]       job_data,
    output logic [NUM_SOLVERS-1:0]     slv_wr_en,
    output logic                       slv_wr_ind,
    output logic [LIMB_INDEX_BITS-1:0] slv_wr_limb,
    output logic [LIMB_BITS-1:0]       slv_wr_data,
    output logic                       slv_wr_num_limbs_en,
    output logic [LIMB_INDEX_BITS-1:0] slv_num_limbs_data,
    output logic                       slv_wr_iter_lim_en,
    output logic [15:0]                slv_iter_lim_data,
    output logic [NUM_SOLVERS-1:0]     slv_start,
    input  logic [NUM_SOLVERS-1:0]     slv_out_ready,
    input  logic [NUM_SOLVERS*16-1:0]  slv_iter_count,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [TAG_BITS-1:0]        res_tag,
    output logic [15:0]                res_count,
    output logic [NUM_SOLVERS-1:0]     busy
);
    import solver_pkg::*;

    localparam int SW = $clog2(NUM_SOLVERS);
    localparam int BW = LIMB_INDEX_BITS + 1;

    sched_state_t               state;
    logic [LIMB_INDEX_BITS-1:0] num_limbs;
    logic [BW-1:0]              beat, wr_k, last_beat;
    logic [SW-1:0]              sel, rr_ptr, free_idx, wr_sel, grant_idx;
    logic                       free_any, arb_any, cfg_hs, job_hs, res_take, wr_hi;
    logic [LIMB_INDEX_BITS-1:0] wr_limb;
    logic [NUM_SOLVERS-1:0]     pending, grant, start_mask, clr_mask;
    logic [TAG_BITS-1:0]        tag_mem [NUM_SOLVERS];

    always_comb begin
        free_idx = '0;
        for (int i = NUM_SOLVERS - 1; i >= 0; i--)
            if (!busy[i]) free_idx = SW'(i);
    end

    assign free_any  = ~&busy;
    assign cfg_ready = (state == S_IDLE) && (busy == '0) && !res_valid;
    assign cfg_hs    = cfg_valid && cfg_ready;

    always_comb begin
        case (state)
            S_IDLE:  job_ready = (num_limbs != '0) && free_any && !cfg_valid;
            S_LOAD:  job_ready = 1'b1;
            default: job_ready = 1'b0;
        endcase
    end
    assign job_hs = job_valid && job_ready;

    // The first beat is accepted in S_IDLE and is always beat 0 of the job.
    assign wr_k      = (state == S_IDLE) ? '0 : beat;
    assign wr_sel    = (state == S_IDLE) ? free_idx : sel;
    assign wr_hi     = wr_k >= {1'b0, num_limbs};
    assign wr_limb   = wr_hi ? LIMB_INDEX_BITS'(wr_k - {1'b0, num_limbs})
                             : wr_k[LIMB_INDEX_BITS-1:0];
    assign last_beat = {num_limbs, 1'b0} - BW'(1);

    assign pending    = busy & slv_out_ready;
    assign res_take   = !res_valid || res_ready;
    assign start_mask = (state == S_START) ? (NUM_SOLVERS'(1) << sel) : '0;
    assign clr_mask   = res_take ? grant : '0;

    rr_arbiter #(.N(NUM_SOLVERS)) u_res_arb (
        .req       (pending),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (arb_any)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= S_IDLE;
            num_limbs           <= '0;
            beat                <= '0;
            sel                 <= '0;
            rr_ptr              <= '0;
            busy                <= '0;
            for (int i = 0; i < NUM_SOLVERS; i++) tag_mem[i] <= '0;
            slv_wr_en           <= '0;
            slv_wr_ind          <= 1'b0;
            slv_wr_limb         <= '0;
            slv_wr_data         <= '0;
            slv_wr_num_limbs_en <= 1'b0;
            slv_num_limbs_data  <= '0;
            slv_wr_iter_lim_en  <= 1'b0;
            slv_iter_lim_data   <= '0;
            slv_start           <= '0;
            res_valid           <= 1'b0;
            res_tag             <= '0;
            res_count           <= '0;
        end else begin
            slv_wr_en           <= '0;
            slv_wr_num_limbs_en <= 1'b0;
            slv_wr_iter_lim_en  <= 1'b0;
            slv_start           <= start_mask;
            busy                <= (busy | start_mask) & ~clr_mask;

            if (job_hs) begin
                slv_wr_en   <= NUM_SOLVERS'(1) << wr_sel;
                slv_wr_ind  <= wr_hi;
                slv_wr_limb <= wr_limb;
                slv_wr_data <= job_data;
                beat        <= wr_k + BW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (cfg_hs) begin
                        num_limbs           <= cfg_num_limbs;
                        slv_wr_num_limbs_en <= 1'b1;
                        slv_num_limbs_data  <= cfg_num_limbs;
                        slv_wr_iter_lim_en  <= 1'b1;
                        slv_iter_lim_data   <= cfg_iter_lim;
                    end else if (job_hs) begin
                        sel               <= free_idx;
                        tag_mem[free_idx] <= job_tag;
                        state             <= S_LOAD;
                    end
                end
                S_LOAD:  if (job_hs && beat == last_beat) state <= S_START;
                default: state <= S_IDLE;
            endcase

            if (res_take) begin
                res_valid <= arb_any;
                if (arb_any) begin
                    res_tag   <= tag_mem[grant_idx];
                    res_count <= slv_iter_count[grant_idx*16 +: 16];
                    rr_ptr    <= grant_idx + SW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_solver_scheduler.sv
// Directed bench for solver_scheduler with a minimal solver model driven by done_req.
module tb_solver_scheduler;
    import solver_pkg::*;

    localparam int NS = 4, LIB = 6, LB = 32, TW = 16;

    logic            clock = 1'b0, reset_n = 1'b0;
    logic            cfg_valid = 1'b0, cfg_ready;
    logic [LIB-1:0]  cfg_num_limbs = '0;
    logic [15:0]     cfg_iter_lim = '0;
    logic            job_valid = 1'b0, job_ready;
    logic [TW-1:0]   job_tag = '0;
    logic [LB-1:0]   job_data = '0;
    logic [NS-1:0]   slv_wr_en, slv_start, slv_out_ready, busy;
    logic            slv_wr_ind, slv_wr_num_limbs_en, slv_wr_iter_lim_en;
    logic [LIB-1:0]  slv_wr_limb, slv_num_limbs_data;
    logic [LB-1:0]   slv_wr_data;
    logic [15:0]     slv_iter_lim_data, res_count;
    logic [NS*16-1:0] slv_iter_count;
    logic            res_valid, res_ready = 1'b1;
    logic [TW-1:0]   res_tag;

    logic [NS-1:0]   rdy_q, done_req = '0;
    logic [15:0]     cnt_val [NS];
    int              checks = 0, errors = 0, nl = 2;

    always #5 clock = ~clock;

    // Solver model: ready drops the moment start is issued, rises on done_req.
    assign slv_out_ready = rdy_q & ~slv_start;
    always @(posedge clock or negedge reset_n)
        if (!reset_n) rdy_q <= '0;
        else          rdy_q <= (rdy_q & ~slv_start) | done_req;

    for (genvar g = 0; g < NS; g++) begin : g_cnt
        assign slv_iter_count[g*16 +: 16] = cnt_val[g];
    end

    solver_scheduler #(.NUM_SOLVERS(NS), .LIMB_INDEX_BITS(LIB), .LIMB_BITS(LB), .TAG_BITS(TW)) dut (
        .clock(clock), .reset_n(reset_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_num_limbs(cfg_num_limbs), .cfg_iter_lim(cfg_iter_lim),
        .job_valid(job_valid), .job_ready(job_ready), .job_tag(job_tag), .job_data(job_data),
        .slv_wr_en(slv_wr_en), .slv_wr_ind(slv_wr_ind), .slv_wr_limb(slv_wr_limb), .slv_wr_data(slv_wr_data),
        .slv_wr_num_limbs_en(slv_wr_num_limbs_en), .slv_num_limbs_data(slv_num_limbs_data),
        .slv_wr_iter_lim_en(slv_wr_iter_lim_en), .slv_iter_lim_data(slv_iter_lim_data),
        .slv_start(slv_start), .slv_out_ready(slv_out_ready), .slv_iter_count(slv_iter_count),
        .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_count(res_count),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input logic [15:0] tag, input int k);
        return 32'hD000_0000 | (32'(tag) << 8) | 32'(k);
    endfunction

    // Sends nb beats of a job; a full job (2*nl beats) also checks the start pulse.
    task automatic send_job(input logic [15:0] tag, input int nb, input int s);
        int w;
        for (int k = 0; k < nb; k++) begin
            job_valid = 1'b1;
            job_tag   = tag;
            job_data  = beat_data(tag, k);
            #1;
            w = 0;
            while (!job_ready && w < 100) begin
                @(negedge clock); #1; w++;
            end
            chk("job_ready", {31'b0, job_ready}, 32'd1);
            @(negedge clock);
            job_valid = 1'b0;
            chk("wr_en",   {28'b0, slv_wr_en}, 32'(1) << s);
            chk("wr_ind",  {31'b0, slv_wr_ind}, (k >= nl) ? 32'd1 : 32'd0);
            chk("wr_limb", {26'b0, slv_wr_limb}, 32'(k % nl));
            chk("wr_data", slv_wr_data, beat_data(tag, k));
        end
        if (nb == 2 * nl) begin
            @(negedge clock);
            chk("start",    {28'b0, slv_start}, 32'(1) << s);
            chk("busy_set", {31'b0, busy[s]}, 32'd1);
        end
    endtask

    task automatic wait_res(input logic [15:0] tag, input logic [15:0] cnt);
        int w = 0;
        while (!res_valid && w < 50) begin
            @(negedge clock); w++;
        end
        chk("res_valid", {31'b0, res_valid}, 32'd1);
        chk("res_tag",   {16'b0, res_tag}, {16'b0, tag});
        chk("res_count", {16'b0, res_count}, {16'b0, cnt});
    endtask

    task automatic finish_solvers(input logic [NS-1:0] m);
        done_req = m;
        @(negedge clock);
        done_req = '0;
    endtask

    initial begin
        for (int i = 0; i < NS; i++) cnt_val[i] = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_busy",   {28'b0, busy}, 32'd0);
        chk("rst_res_v",  {31'b0, res_valid}, 32'd0);
        chk("rst_start",  {28'b0, slv_start}, 32'd0);
        chk("rst_cfg_rdy", {31'b0, cfg_ready}, 32'd1);

        // No config yet: jobs are refused
        job_valid = 1'b1; job_data = 32'h1234;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("nocfg_job_ready", {31'b0, job_ready}, 32'd0);
            @(negedge clock); #1;
        end
        job_valid = 1'b0;

        cfg_valid = 1'b1; cfg_num_limbs = 6'd2; cfg_iter_lim = 16'd100;
        #1;
        chk("cfg_ready", {31'b0, cfg_ready}, 32'd1);
        @(negedge clock);
        cfg_valid = 1'b0;
        chk("nl_en",   {31'b0, slv_wr_num_limbs_en}, 32'd1);
        chk("nl_data", {26'b0, slv_num_limbs_data}, 32'd2);
        chk("il_en",   {31'b0, slv_wr_iter_lim_en}, 32'd1);
        chk("il_data", {16'b0, slv_iter_lim_data}, 32'd100);
        @(negedge clock);
        chk("cfg_strobe_off", {30'b0, slv_wr_num_limbs_en, slv_wr_iter_lim_en}, 32'd0);

        // Single job
        send_job(16'h0005, 4, 0);
        repeat (20) @(negedge clock);
        cnt_val[0] = 16'd37;
        finish_solvers(4'b0001);
        wait_res(16'h0005, 16'd37);
        @(negedge clock);
        chk("single_busy", {28'b0, busy}, 32'd0);
        chk("single_res_v", {31'b0, res_valid}, 32'd0);

        // Fill all solvers, fifth job stalls until one frees
        for (int s = 0; s < NS; s++) send_job(16'h0011 + 16'(s), 4, s);
        chk("fill_busy", {28'b0, busy}, 32'hF);
        job_valid = 1'b1; job_tag = 16'h0015; job_data = beat_data(16'h0015, 0);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("full_job_ready", {31'b0, job_ready}, 32'd0);
            @(negedge clock); #1;
        end
        cnt_val[0] = 16'd100;
        finish_solvers(4'b0001);
        wait_res(16'h0011, 16'd100);
        send_job(16'h0015, 4, 0);

        // Backpressure: solvers 1 and 3 finish together
        res_ready = 1'b0;
        cnt_val[1] = 16'd200; cnt_val[3] = 16'd300;
        finish_solvers(4'b1010);
        wait_res(16'h0012, 16'd200);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("hold_v",   {31'b0, res_valid}, 32'd1);
            chk("hold_tag", {16'b0, res_tag}, 32'h12);
            chk("hold_cnt", {16'b0, res_count}, 32'd200);
        end
        res_ready = 1'b1;
        @(negedge clock);
        chk("bp2_tag", {16'b0, res_tag}, 32'h14);
        chk("bp2_cnt", {16'b0, res_count}, 32'd300);
        @(negedge clock);
        chk("bp_res_v", {31'b0, res_valid}, 32'd0);
        chk("bp_busy", {28'b0, busy}, 32'b0101);

        // Limit reached alongside a normal result, pointer back at 0
        cnt_val[0] = 16'd55; cnt_val[2] = ITER_COUNT_NONE;
        finish_solvers(4'b0101);
        wait_res(16'h0015, 16'd55);
        @(negedge clock);
        chk("lim_tag", {16'b0, res_tag}, 32'h13);
        chk("lim_cnt", {16'b0, res_count}, 32'hFFFF);
        @(negedge clock);
        chk("lim_busy", {28'b0, busy}, 32'd0);

        // Reset in the middle of a load
        send_job(16'h0066, 4, 0);
        send_job(16'h0077, 2, 1);
        reset_n = 1'b0;
        #1;
        chk("mrst_wr_en", {28'b0, slv_wr_en}, 32'd0);
        chk("mrst_busy",  {28'b0, busy}, 32'd0);
        chk("mrst_res_v", {31'b0, res_valid}, 32'd0);
        chk("mrst_wdata", slv_wr_data, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        job_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_job_ready", {31'b0, job_ready}, 32'd0);
            @(negedge clock); #1;
        end
        job_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
